// File: rtl/uart_readback_tx_if.sv
// Read-word handshake from the PSRAM read path into the UART response serializer.
interface uart_readback_tx_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [22:0] rd_address;
  logic [15:0] rd_data;

  modport master (output rd_valid, output rd_address, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_address, input rd_data, output rd_ready);
endinterface

// File: rtl/uart_readback_tx.sv
// Serializes one {address, data} read word into a 7-byte 8N1 UART frame: header, addr, data, xor checksum.
// tx drops the cycle after accept; a frame is 70*CLKS_PER_BIT cycles; rd_ready stays low until frame_done.
module uart_readback_tx #(
  parameter int          CLK_FREQ     = 27_000_000,
  parameter int          BAUD         = 115_200,
  parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_readback_tx_if.slave  rd,
  output logic               uart_tx,
  output logic               busy,
  output logic               frame_done
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_readback_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  localparam int TW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [55:0]   sr;

  logic [7:0]    b1, b2, b3, b4, b5, b6;
  logic [55:0]   frame_word;
  logic          bit_end;
  logic          accept;

  assign b1         = {1'b0, rd.rd_address[22:16]};
  assign b2         = rd.rd_address[15:8];
  assign b3         = rd.rd_address[7:0];
  assign b4         = rd.rd_data[15:8];
  assign b5         = rd.rd_data[7:0];
  assign b6         = HEADER ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;
  // Byte 0 sits in the low bits so the frame shifts out LSB first, byte after byte.
  assign frame_word = {b6, b5, b4, b3, b2, b1, HEADER};
  assign bit_end    = (tmr == TW'(CLKS_PER_BIT - 1));
  assign accept     = rd.rd_valid && rd.rd_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      sr          <= '0;
      uart_tx     <= 1'b1;
      rd.rd_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE) begin
        tmr <= bit_end ? '0 : tmr + 1'b1;
      end
      case (state)
        IDLE: begin
          // busy covers the frame_done cycle, then drops unless a new word is taken right away.
          if (accept) begin
            sr          <= frame_word;
            rd.rd_ready <= 1'b0;
            busy        <= 1'b1;
            uart_tx     <= 1'b0;
            tmr         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            state       <= START;
          end else begin
            rd.rd_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            uart_tx <= sr[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            sr <= sr >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= sr[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_idx == 3'd6) begin
              byte_idx    <= '0;
              frame_done  <= 1'b1;
              rd.rd_ready <= 1'b1;
              state       <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              uart_tx  <= 1'b0;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
